dmg_serial: RTL and testbench

DMG_SERIAL -- requirements
Module: dmg_serial

---
 rtl/dmg_serial_pkg.sv | 16 +
 rtl/dmg_sync_edge.sv | 25 ++
 rtl/dmg_serial.sv | 172 +++++++++++++++++
 tb/tb_dmg_serial.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmg_serial_pkg.sv
// rtl/dmg_serial_pkg.sv - shared constants and types for the DMG serial port
package dmg_serial_pkg;

  localparam logic [15:0] SB_ADDR = 16'hFF01;
  localparam logic [15:0] SC_ADDR = 16'hFF02;

  // Position of the serial request in the CPU interrupt trigger vector
  localparam int IRQ_BIT_SERIAL = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2
  } state_e;

endpackage

// File: rtl/dmg_sync_edge.sv
// rtl/dmg_sync_edge.sv - two-flop synchronizer with rise/fall edge pulses
module dmg_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sck,
  output logic rise,
  output logic fall
);

  // sync[1:0] is the metastability chain, sync[2] holds the previous clean level
  logic [2:0] sync;

  // Shift the asynchronous clock through the chain; idle level is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 3'b111;
    end else begin
      sync <= {sync[1:0], sck};
    end
  end

  assign rise = sync[1] & ~sync[2];
  assign fall = ~sync[1] & sync[2];

endmodule

// File: rtl/dmg_serial.sv
// rtl/dmg_serial.sv - DMG serial port: SB/SC registers and 8-bit shift engine
module dmg_serial
  import dmg_serial_pkg::*;
#(
  parameter int DIV_HALF = 256
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic [15:0] ADDR,
  input  logic [7:0]  WDATA,
  input  logic        WR_STB,
  input  logic        RD_STB,
  output logic [7:0]  RDATA,
  output logic        SEL,
  input  logic        SIN,
  output logic        SOUT,
  input  logic        SCK_IN,
  output logic        SCK_OUT,
  output logic        IRQ_SERIAL,
  output logic [7:0]  TX_BYTE,
  output logic        TX_VALID
);

  localparam int DW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV_HALF - 1);

  state_e        state;
  logic [7:0]    sb;
  logic [7:0]    tx_latch;
  logic          busy;
  logic          clksel;
  logic [3:0]    bit_cnt;
  logic [DW-1:0] div_cnt;
  logic          ext_rise;
  logic          ext_fall;
  logic          wr_sb;
  logic          wr_sc;
  logic          phase_end;
  logic          done;
  logic          unused_rd;

  // Reads are side-effect free, so the strobe is intentionally not consumed
  assign unused_rd = RD_STB;

  assign wr_sb     = WR_STB && (ADDR == SB_ADDR);
  assign wr_sc     = WR_STB && (ADDR == SC_ADDR);
  assign phase_end = (div_cnt == DIV_LAST);
  assign done      = (state == SHIFT_HI) && (bit_cnt == 4'd8);
  assign SEL       = (ADDR == SB_ADDR) || (ADDR == SC_ADDR);

  dmg_sync_edge u_sync (
    .clk   (CLK),
    .rst_n (nRESET),
    .sck   (SCK_IN),
    .rise  (ext_rise),
    .fall  (ext_fall)
  );

  // Register read mux; unused SC bits read as ones
  always_comb begin
    RDATA = 8'hFF;
    if (ADDR == SB_ADDR) begin
      RDATA = sb;
    end else if (ADDR == SC_ADDR) begin
      RDATA = {busy, 6'b111111, clksel};
    end
  end

  // Shift FSM; an SC write is applied after the FSM so completion is reported first
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state      <= IDLE;
      sb         <= 8'h00;
      tx_latch   <= 8'h00;
      busy       <= 1'b0;
      clksel     <= 1'b0;
      bit_cnt    <= 4'd0;
      div_cnt    <= '0;
      SOUT       <= 1'b1;
      SCK_OUT    <= 1'b1;
      IRQ_SERIAL <= 1'b0;
      TX_VALID   <= 1'b0;
      TX_BYTE    <= 8'h00;
    end else begin
      IRQ_SERIAL <= 1'b0;
      TX_VALID   <= 1'b0;

      if (wr_sb && !busy) begin
        sb <= WDATA;
      end

      case (state)
        IDLE: begin
          div_cnt <= '0;
          if (busy) begin
            state   <= SHIFT_LO;
            SCK_OUT <= !clksel;
            SOUT    <= sb[7];
          end
        end
        SHIFT_LO: begin
          if (clksel) begin
            if (phase_end) begin
              state   <= SHIFT_HI;
              SCK_OUT <= 1'b1;
              sb      <= {sb[6:0], SIN};
              bit_cnt <= bit_cnt + 4'd1;
              div_cnt <= '0;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end else begin
            if (ext_fall) begin
              SOUT <= sb[7];
            end
            if (ext_rise) begin
              state   <= SHIFT_HI;
              sb      <= {sb[6:0], SIN};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        SHIFT_HI: begin
          if (done) begin
            state      <= IDLE;
            busy       <= 1'b0;
            bit_cnt    <= 4'd0;
            div_cnt    <= '0;
            SCK_OUT    <= 1'b1;
            IRQ_SERIAL <= 1'b1;
            TX_VALID   <= 1'b1;
            TX_BYTE    <= tx_latch;
          end else if (clksel) begin
            if (phase_end) begin
              state   <= SHIFT_LO;
              SCK_OUT <= 1'b0;
              SOUT    <= sb[7];
              div_cnt <= '0;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end else if (ext_fall) begin
            state <= SHIFT_LO;
            SOUT  <= sb[7];
          end
        end
        default: state <= IDLE;
      endcase

      if (wr_sc) begin
        clksel <= WDATA[0];
        if (WDATA[7]) begin
          // Start or restart from bit 0 with the current SB contents
          busy     <= 1'b1;
          bit_cnt  <= 4'd0;
          div_cnt  <= '0;
          tx_latch <= sb;
          state    <= IDLE;
          SCK_OUT  <= 1'b1;
        end else if (busy) begin
          // Abort: SB keeps whatever has been shifted so far
          busy    <= 1'b0;
          bit_cnt <= 4'd0;
          div_cnt <= '0;
          state   <= IDLE;
          SCK_OUT <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmg_serial.sv
// tb/tb_dmg_serial.sv - self-checking bench for dmg_serial
module tb_dmg_serial;
  import dmg_serial_pkg::*;

  localparam int DH     = 4;
  localparam int DONE_O = 2 + 15 * DH;

  logic        clk = 1'b0;
  logic        nRESET = 1'b0;
  logic [15:0] ADDR = 16'h0000;
  logic [7:0]  WDATA = 8'h00;
  logic        WR_STB = 1'b0;
  logic        RD_STB = 1'b0;
  logic [7:0]  RDATA;
  logic        SEL;
  logic        SIN = 1'b0;
  logic        SOUT;
  logic        SCK_IN = 1'b1;
  logic        SCK_OUT;
  logic        IRQ_SERIAL;
  logic [7:0]  TX_BYTE;
  logic        TX_VALID;
  logic [7:0]  cpu_irq_trig;
  logic        irq_line;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign cpu_irq_trig = 8'(IRQ_SERIAL) << IRQ_BIT_SERIAL;
  assign irq_line     = cpu_irq_trig[IRQ_BIT_SERIAL];

  dmg_serial #(.DIV_HALF(DH)) dut (
    .CLK        (clk),
    .nRESET     (nRESET),
    .ADDR       (ADDR),
    .WDATA      (WDATA),
    .WR_STB     (WR_STB),
    .RD_STB     (RD_STB),
    .RDATA      (RDATA),
    .SEL        (SEL),
    .SIN        (SIN),
    .SOUT       (SOUT),
    .SCK_IN     (SCK_IN),
    .SCK_OUT    (SCK_OUT),
    .IRQ_SERIAL (IRQ_SERIAL),
    .TX_BYTE    (TX_BYTE),
    .TX_VALID   (TX_VALID)
  );

  typedef struct {
    logic        wr;
    logic [15:0] wa;
    logic [7:0]  wd;
    logic [15:0] ra;
    logic [7:0]  rd;
    logic        sel;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    ADDR = a;
    WDATA = d;
    WR_STB = 1'b1;
    tick();
    WR_STB = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] exp, input logic exp_sel, input string name);
    ADDR = a;
    RD_STB = 1'b1;
    #1;
    chk(name, RDATA, exp);
    chk({name, "_sel"}, SEL, exp_sel);
    RD_STB = 1'b0;
  endtask

  // Internal-clock transfer of byte b while SIN supplies bits of s, MSB first
  task automatic xfer_int(input logic [7:0] b, input logic [7:0] s);
    int k;
    wr(SB_ADDR, b);
    wr(SC_ADDR, 8'h81);
    for (int o = 1; o <= DONE_O + 2; o++) begin
      k = (o - 1 <= DH) ? 0 : (o - 1 - DH + 2 * DH - 1) / (2 * DH);
      if (k > 7) k = 7;
      SIN = s[7 - k];
      tick();
      chk("sck_out", SCK_OUT,
          (((o - 1) / (2 * DH)) <= 7 && ((o - 1) % (2 * DH)) < DH) ? 0 : 1);
      chk("irq", irq_line, o == DONE_O);
      chk("tx_valid", TX_VALID, o == DONE_O);
      if (((o - 1) % (2 * DH)) == 0 && ((o - 1) / (2 * DH)) <= 7)
        chk("sout", SOUT, b[7 - (o - 1) / (2 * DH)]);
      if (o == DONE_O) chk("tx_byte", TX_BYTE, b);
    end
    rd(SB_ADDR, s, 1'b1, "sb_final");
    rd(SC_ADDR, 8'h7F, 1'b1, "sc_final");
  endtask

  initial begin
    int irqs;
    int at;
    logic [7:0] rb;
    logic [7:0] rs;
    logic [7:0] pat;
    logic [7:0] sb0;

    // Reset state
    repeat (2) tick();
    chk("rst_sout", SOUT, 1);
    chk("rst_sck", SCK_OUT, 1);
    chk("rst_irq", IRQ_SERIAL, 0);
    chk("rst_txv", TX_VALID, 0);
    chk("rst_txb", TX_BYTE, 8'h00);
    rd(SB_ADDR, 8'h00, 1'b1, "rst_sb");
    rd(SC_ADDR, 8'h7E, 1'b1, "rst_sc");
    #2 nRESET = 1'b1;
    tick();

    // Register access table
    vt[0] = '{1'b0, 16'h0000, 8'h00, 16'hFF00, 8'hFF, 1'b0};
    vt[1] = '{1'b0, 16'h0000, 8'h00, 16'hFF03, 8'hFF, 1'b0};
    vt[2] = '{1'b1, SB_ADDR,  8'h3C, SB_ADDR,  8'h3C, 1'b1};
    vt[3] = '{1'b1, SC_ADDR,  8'h01, SC_ADDR,  8'h7F, 1'b1};
    vt[4] = '{1'b1, SC_ADDR,  8'h7E, SC_ADDR,  8'h7E, 1'b1};
    vt[5] = '{1'b1, 16'hFF00, 8'h12, SB_ADDR,  8'h3C, 1'b1};
    vt[6] = '{1'b1, SB_ADDR,  8'hA7, SC_ADDR,  8'h7E, 1'b1};
    vt[7] = '{1'b0, 16'h0000, 8'h00, SB_ADDR,  8'hA7, 1'b1};
    vt[8] = '{1'b0, 16'h0000, 8'h00, 16'h0001, 8'hFF, 1'b0};
    vt[9] = '{1'b1, 16'hFF02, 8'h00, 16'hFF01, 8'hA7, 1'b1};
    for (int i = 0; i < 10; i++) begin
      if (vt[i].wr) wr(vt[i].wa, vt[i].wd);
      rd(vt[i].ra, vt[i].rd, vt[i].sel, $sformatf("reg%0d", i));
      tick();
    end

    // Scenario 1 then randomized internal transfers
    xfer_int(8'h41, 8'hFF);
    for (int r = 0; r < 4; r++) begin
      rb = 8'($urandom);
      rs = 8'($urandom);
      xfer_int(rb, rs);
    end

    // SB write while busy is ignored
    SIN = 1'b0;
    wr(SB_ADDR, 8'h96);
    wr(SC_ADDR, 8'h81);
    repeat (10) tick();
    wr(SB_ADDR, 8'h55);
    rd(SB_ADDR, 8'h2C, 1'b1, "sb_busy_wr");
    at = 0;
    for (int c = 12; c <= DONE_O + 10; c++) begin
      tick();
      if (irq_line && at == 0) at = c;
    end
    chk("busy_wr_irq_at", at, DONE_O);
    chk("busy_wr_txb", TX_BYTE, 8'h96);

    // Reset mid-transfer
    SIN = 1'b1;
    wr(SB_ADDR, 8'hF0);
    wr(SC_ADDR, 8'h81);
    repeat (19) tick();
    #2 nRESET = 1'b0;
    #1;
    chk("mid_rst_sout", SOUT, 1);
    chk("mid_rst_sck", SCK_OUT, 1);
    chk("mid_rst_irq", IRQ_SERIAL, 0);
    chk("mid_rst_txv", TX_VALID, 0);
    chk("mid_rst_txb", TX_BYTE, 8'h00);
    rd(SB_ADDR, 8'h00, 1'b1, "mid_rst_sb");
    rd(SC_ADDR, 8'h7E, 1'b1, "mid_rst_sc");
    irqs = 0;
    repeat (3) begin
      tick();
      irqs += int'(irq_line);
    end
    #2 nRESET = 1'b1;
    tick();
    repeat (DONE_O) begin
      tick();
      irqs += int'(irq_line);
    end
    chk("mid_rst_no_irq", irqs, 0);
    xfer_int(8'hC5, 8'h3A);

    // External clock, SIN pattern A5
    pat = 8'hA5;
    sb0 = 8'h3C;
    wr(SB_ADDR, sb0);
    wr(SC_ADDR, 8'h80);
    irqs = 0;
    for (int k = 0; k < 8; k++) begin
      SIN = pat[7 - k];
      SCK_IN = 1'b0;
      repeat (10) begin
        tick();
        irqs += int'(irq_line);
        chk("ext_sck_out", SCK_OUT, 1);
      end
      chk("ext_sout", SOUT, sb0[7 - k]);
      SCK_IN = 1'b1;
      repeat (10) begin
        tick();
        irqs += int'(irq_line);
        chk("ext_sck_out", SCK_OUT, 1);
      end
    end
    repeat (10) begin
      tick();
      irqs += int'(irq_line);
    end
    chk("ext_irqs", irqs, 1);
    rd(SB_ADDR, 8'hA5, 1'b1, "ext_sb");
    rd(SC_ADDR, 8'h7E, 1'b1, "ext_sc");

    // Abort after three bits
    SIN = 1'b0;
    wr(SB_ADDR, 8'hC3);
    wr(SC_ADDR, 8'h81);
    repeat (4 * DH + DH + 1) tick();
    wr(SC_ADDR, 8'h01);
    chk("abort_sck", SCK_OUT, 1);
    rd(SC_ADDR, 8'h7F, 1'b1, "abort_sc");
    rd(SB_ADDR, 8'h18, 1'b1, "abort_sb");
    irqs = 0;
    repeat (DONE_O + 10) begin
      tick();
      irqs += int'(irq_line);
    end
    chk("abort_irqs", irqs, 0);

    // Restart written on the completion cycle
    SIN = 1'b1;
    wr(SB_ADDR, 8'h5A);
    wr(SC_ADDR, 8'h81);
    repeat (DONE_O - 1) tick();
    wr(SC_ADDR, 8'h81);
    chk("coll_irq1", irq_line, 1);
    chk("coll_txb1", TX_BYTE, 8'h5A);
    irqs = 0;
    at = 0;
    for (int c = 1; c <= DONE_O + 10; c++) begin
      tick();
      irqs += int'(irq_line);
      if (irq_line && at == 0) at = c;
    end
    chk("coll_irqs2", irqs, 1);
    chk("coll_irq2_at", at, DONE_O);
    chk("coll_txb2", TX_BYTE, 8'hFF);
    rd(SB_ADDR, 8'hFF, 1'b1, "coll_sb");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
